// File: rtl/rs_cmd_gen.sv
// Debounced set/clear command generator driving the S/R inputs of a downstream rs_ff.
// Issues fixed-length, mutually exclusive S or R pulses and tracks the expected Q.

module rs_cmd_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_filt;
  logic       r_filt_d;
  logic [7:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == 8'(DEBOUNCE - 1)) begin
        // DEBOUNCE-th consecutive disagreeing cycle: accept the new level
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_rise = r_filt & ~r_filt_d;

endmodule

module rs_cmd_gen #(
  parameter int DEBOUNCE  = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic S,
  output logic R,
  output logic busy,
  output logic q_exp,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_pulse_cnt;
  logic       r_pend_set;
  logic       r_pend_clr;

  logic w_set_req;
  logic w_clr_req;
  logic w_both_req;
  logic w_eff_set;
  logic w_eff_clr;

  rs_cmd_filter #(.DEBOUNCE(DEBOUNCE)) u_set_filter (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (set_in),
    .o_rise (w_set_req)
  );

  rs_cmd_filter #(.DEBOUNCE(DEBOUNCE)) u_clr_filter (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (clr_in),
    .o_rise (w_clr_req)
  );

  assign w_both_req = w_set_req & w_clr_req;

  // A fresh request in the IDLE cycle is newer than the pending one, so it takes priority.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_eff_set = 1'b0;
    w_eff_clr = 1'b0;
    if (!w_both_req) begin
      if (w_set_req || w_clr_req) begin
        w_eff_set = w_set_req;
        w_eff_clr = w_clr_req;
      end else begin
        w_eff_set = r_pend_set;
        w_eff_clr = r_pend_clr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pulse_cnt <= '0;
      r_pend_set  <= 1'b0;
      r_pend_clr  <= 1'b0;
      S           <= 1'b0;
      R           <= 1'b0;
      busy        <= 1'b0;
      q_exp       <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        if (w_both_req) begin
          r_pend_set <= 1'b0;
          r_pend_clr <= 1'b0;
          err        <= 1'b1;
        end else if (w_set_req) begin
          r_pend_set <= 1'b1;
          r_pend_clr <= 1'b0;
        end else if (w_clr_req) begin
          r_pend_set <= 1'b0;
          r_pend_clr <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          r_pend_set <= 1'b0;
          r_pend_clr <= 1'b0;
          if (w_both_req) begin
            err <= 1'b1;
          end else if (w_eff_set && !q_exp) begin
            r_state     <= SET_P;
            r_pulse_cnt <= '0;
            S           <= 1'b1;
            busy        <= 1'b1;
            q_exp       <= 1'b1;
          end else if (w_eff_clr && q_exp) begin
            r_state     <= CLR_P;
            r_pulse_cnt <= '0;
            R           <= 1'b1;
            busy        <= 1'b1;
            q_exp       <= 1'b0;
          end
        end
        SET_P, CLR_P: begin
          if (r_pulse_cnt == 4'(PULSE_LEN - 1)) begin
            r_state <= GAP;
            S       <= 1'b0;
            R       <= 1'b0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 4'd1;
          end
        end
        GAP: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          S       <= 1'b0;
          R       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_cmd_gen.sv
// Self-checking bench for rs_cmd_gen: scenario table, hand-written corner sequences
// and a long random run compared against a behavioural command model.

module tb_rs_cmd_gen;

  localparam int D  = 4;
  localparam int PL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic S, R, busy, q_exp, err;

  int n_tests = 0;
  int n_fail  = 0;

  rs_cmd_gen #(.DEBOUNCE(D), .PULSE_LEN(PL)) dut (
    .clk    (clk),
    .rst    (rst),
    .set_in (set_in),
    .clr_in (clr_in),
    .S      (S),
    .R      (R),
    .busy   (busy),
    .q_exp  (q_exp),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {C_NONE, C_SET, C_CLR} cmd_t;

  bit   m_hist [2][2];
  int   m_run  [2];
  bit   m_filt [2];
  bit   m_rise [2];
  cmd_t m_pend;
  cmd_t m_kind;
  int   m_left;
  bit   m_q;
  bit   m_err;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_hist[ch][0] = 0;
      m_hist[ch][1] = 0;
      m_run[ch]     = 0;
      m_filt[ch]    = 0;
      m_rise[ch]    = 0;
    end
    m_pend = C_NONE;
    m_kind = C_NONE;
    m_left = 0;
    m_q    = 0;
    m_err  = 0;
  endtask

  // One rising edge; raw_s/raw_c are the levels sampled at that edge.
  task automatic model_step(input bit raw_s, input bit raw_c);
    bit   rq_s, rq_c, x;
    bit   raw [2];
    cmd_t cmd;
    rq_s = m_rise[0];
    rq_c = m_rise[1];
    raw[0] = raw_s;
    raw[1] = raw_c;
    if (m_left > 0) begin
      m_left--;
      if (rq_s && rq_c) begin
        m_pend = C_NONE;
        m_err  = 1;
      end else if (rq_s) m_pend = C_SET;
      else if (rq_c) m_pend = C_CLR;
    end else begin
      cmd = C_NONE;
      if (rq_s && rq_c) m_err = 1;
      else if (rq_s) cmd = C_SET;
      else if (rq_c) cmd = C_CLR;
      else cmd = m_pend;
      m_pend = C_NONE;
      if (cmd == C_SET && !m_q) begin
        m_q = 1; m_kind = C_SET; m_left = PL + 1;
      end else if (cmd == C_CLR && m_q) begin
        m_q = 0; m_kind = C_CLR; m_left = PL + 1;
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      x = m_hist[ch][1];
      m_hist[ch][1] = m_hist[ch][0];
      m_hist[ch][0] = raw[ch];
      m_rise[ch] = 0;
      if (x != m_filt[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_filt[ch] = x;
          m_run[ch]  = 0;
          m_rise[ch] = x;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic ms, mr;
    ms = (m_kind == C_SET) && (m_left > 1);
    mr = (m_kind == C_CLR) && (m_left > 1);
    return {ms, mr, (m_left > 0), m_q, m_err};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    set_in = 1'b0;
    clr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int set_len;
    int clr_off;
    int clr_len;
    int exp_s;
    int exp_r;
    bit exp_q;
    bit exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int s_cnt, r_cnt;
    logic [4:0] exp_o;
    logic [4:0] act_o;

    vecs[0] = '{3,  0, 0,  0, 0, 1'b0, 1'b0};  // set glitch rejected
    vecs[1] = '{4,  0, 0,  2, 0, 1'b1, 1'b0};  // minimum accepted set
    vecs[2] = '{20, 0, 0,  2, 0, 1'b1, 1'b0};  // long set, one pulse
    vecs[3] = '{0,  0, 10, 0, 0, 1'b0, 1'b0};  // idempotent clear
    vecs[4] = '{10, 0, 10, 0, 0, 1'b0, 1'b1};  // simultaneous -> err
    vecs[5] = '{10, 30, 10, 2, 2, 1'b0, 1'b0}; // set then clear later
    vecs[6] = '{10, 2, 10, 2, 2, 1'b0, 1'b0};  // clear pending during SET_P
    vecs[7] = '{10, 1, 3,  2, 0, 1'b1, 1'b0};  // clear glitch rejected
    vecs[8] = '{4,  20, 4, 2, 2, 1'b0, 1'b0};  // minimum set and clear
    vecs[9] = '{10, 1, 10, 2, 2, 1'b0, 1'b0};  // clear one cycle after set

    do_reset();
    check("reset_outputs", {S, R, busy, q_exp, err}, 5'b0);

    // -------- table-driven scenarios --------
    for (int v = 0; v < 10; v++) begin
      do_reset();
      s_cnt = 0;
      r_cnt = 0;
      for (int c = 0; c < 80; c++) begin
        set_in = (c < vecs[v].set_len);
        clr_in = (c >= vecs[v].clr_off) && (c < vecs[v].clr_off + vecs[v].clr_len);
        tick();
        if (S) s_cnt++;
        if (R) r_cnt++;
      end
      check($sformatf("vec%0d_s_cycles", v), 32'(s_cnt), 32'(vecs[v].exp_s));
      check($sformatf("vec%0d_r_cycles", v), 32'(r_cnt), 32'(vecs[v].exp_r));
      check($sformatf("vec%0d_q_exp", v), q_exp, vecs[v].exp_q);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
    end

    // -------- set latency and pulse shape from reset release --------
    do_reset();
    set_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("lat_S_e%0d", e), S, (e >= D + 3) && (e < D + 3 + PL));
      check($sformatf("lat_busy_e%0d", e), busy, (e >= D + 3) && (e <= D + 3 + PL));
      check($sformatf("lat_q_e%0d", e), q_exp, (e >= D + 3));
      check($sformatf("lat_R_e%0d", e), R, 1'b0);
    end

    // -------- pending clear arriving during SET_P --------
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      set_in = 1'b1;
      clr_in = (e >= 3);
      tick();
      check($sformatf("pend_S_e%0d", e), S, (e == 7) || (e == 8));
      check($sformatf("pend_R_e%0d", e), R, (e == 11) || (e == 12));
    end
    check("pend_q_final", q_exp, 1'b0);

    // -------- simultaneous requests, err sticky --------
    do_reset();
    s_cnt = 0;
    set_in = 1'b1;
    clr_in = 1'b1;
    repeat (10) begin
      tick();
      if (S || R) s_cnt++;
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    repeat (100) begin
      tick();
      if (S || R) s_cnt++;
    end
    check("simul_no_pulse", 32'(s_cnt), 32'd0);
    check("simul_err_sticky", err, 1'b1);
    check("simul_q", q_exp, 1'b0);

    // -------- reset during second S cycle --------
    do_reset();
    set_in = 1'b1;
    repeat (D + 4) tick();
    check("rstmid_S_before", S, 1'b1);
    #2;
    rst    = 1'b1;
    set_in = 1'b0;
    #1;
    check("rstmid_async_clear", {S, R, busy, q_exp, err}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r_cnt = 0;
    clr_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) clr_in = 1'b0;
      tick();
      if (R) r_cnt++;
    end
    check("rstmid_idem_clear_R", 32'(r_cnt), 32'd0);
    check("rstmid_q", q_exp, 1'b0);

    // -------- random run against behavioural model --------
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        set_in = ~set_in;
        clr_in = set_in;
      end else begin
        if ($urandom_range(0, 7) == 0) set_in = ~set_in;
        if ($urandom_range(0, 7) == 0) clr_in = ~clr_in;
      end
      tick();
      model_step(set_in, clr_in);
      exp_o = model_out();
      act_o = {S, R, busy, q_exp, err};
      check("rand_outputs", act_o, exp_o);
      check("rand_S_and_R", S & R, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
